blake512_msg_loader: RTL and testbench

Message front end of the BLAKE-512 core. Accepts the message as a stream of 64-bit big-endian words and assembles 1024-bit message blocks. Applies BLAKE-512 padding, the 0x80…01 marker and the 128-bit length field, and keeps the bit counter t. Hands each block to the round controller by pulsing its start input, then holds the block until the round engine reports completion.

---
 rtl/blake512_pkg.sv | 22 ++
 rtl/blake512_pad_word.sv | 28 ++
 rtl/blake512_msg_loader.sv | 172 +++++++++++++++++
 tb/tb_blake512_msg_loader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blake512_pkg.sv
// Shared types and constants for the BLAKE-512 message front end.
// Holds the loader FSM state encoding and the fixed block layout indices.
package blake512_pkg;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_PAD,
        ST_RUN,
        ST_XPAD
    } state_t;

    localparam logic [7:0] PAD_BYTE     = 8'h80;
    localparam int         LEN_HI_IDX   = 14;
    localparam int         LEN_LO_IDX   = 15;
    localparam int         FIN_BIT_WORD = 13;

    // Byte counts above a full 64-bit word saturate to a full word.
    function automatic logic [3:0] clamp_bytes(input logic [3:0] b);
        return (b > 4'd8) ? 4'd8 : b;
    endfunction

endpackage

// File: rtl/blake512_pad_word.sv
// Masks a big-endian word to its leading i_bytes bytes and, when i_mark is set,
// places the 0x80 padding marker in the first byte after the kept data.
module blake512_pad_word
    import blake512_pkg::*;
#(
    parameter int WORD_W = 64
) (
    input  logic [WORD_W-1:0] i_word,
    input  logic [3:0]        i_bytes,
    input  logic              i_mark,
    output logic [WORD_W-1:0] o_word
);

    localparam int NBYTES = WORD_W / 8;

    // NOTE: o_word gets a full default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        o_word = '0;
        for (int j = 0; j < NBYTES; j++) begin
            if (j < int'(i_bytes)) begin
                o_word[WORD_W-1-8*j -: 8] = i_word[WORD_W-1-8*j -: 8];
            end else if ((j == int'(i_bytes)) && i_mark) begin
                o_word[WORD_W-1-8*j -: 8] = PAD_BYTE;
            end
        end
    end

endmodule

// File: rtl/blake512_msg_loader.sv
// BLAKE-512 message loader: packs 64-bit words into 1024-bit blocks, applies
// padding and the length field, and hands blocks to the round controller.
module blake512_msg_loader
    import blake512_pkg::*;
#(
    parameter int WORD_W    = 64,
    parameter int BLK_WORDS = 16
) (
    input  logic                        clk,
    input  logic                        rstb,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WORD_W-1:0]           in_data,
    input  logic                        in_last,
    input  logic [3:0]                  in_bytes,
    output logic                        blk_start,
    output logic [BLK_WORDS*WORD_W-1:0] blk_data,
    output logic [127:0]                blk_t,
    output logic                        blk_final,
    input  logic                        core_done
);

    // Word 0 is the leftmost element so the packed block matches the output order.
    typedef logic [0:BLK_WORDS-1][WORD_W-1:0] block_t;

    localparam logic [WORD_W-1:0] MARK_WORD = {PAD_BYTE, {(WORD_W-8){1'b0}}};

    state_t        r_state;
    logic [3:0]    r_wi;
    logic [127:0]  r_len;
    logic          r_xpad_pending;
    logic          r_p128;
    block_t        r_buf;
    block_t        r_blk_data;
    logic          r_blk_start;
    logic          r_blk_final;
    logic [127:0]  r_blk_t;

    logic          w_accept;
    logic [3:0]    w_bytes;
    logic [7:0]    w_p;
    logic [127:0]  w_len_next;
    logic [WORD_W-1:0] w_pad;
    block_t        w_fill;
    block_t        w_pad_blk;
    block_t        w_xpad_blk;

    assign in_ready   = (r_state == ST_FILL) && rstb;
    assign w_accept   = in_valid && in_ready;
    assign w_bytes    = in_last ? clamp_bytes(in_bytes) : 4'd8;
    assign w_p        = {1'b0, r_wi, 3'b000} + {4'b0000, w_bytes};
    assign w_len_next = r_len + {121'd0, w_bytes, 3'b000};

    assign blk_start = r_blk_start;
    assign blk_data  = r_blk_data;
    assign blk_t     = r_blk_t;
    assign blk_final = r_blk_final;

    blake512_pad_word #(
        .WORD_W (WORD_W)
    ) u_pad_word (
        .i_word  (in_data),
        .i_bytes (w_bytes),
        .i_mark  (in_last),
        .o_word  (w_pad)
    );

    // Buffer with the incoming word merged at wi; a full last word pushes the marker into wi+1.
    always_comb begin
        w_fill = '0;
        for (int k = 0; k < BLK_WORDS; k++) begin
            if (k < int'(r_wi)) begin
                w_fill[k] = r_buf[k];
            end else if (k == int'(r_wi)) begin
                w_fill[k] = w_pad;
            end else if ((k == int'(r_wi) + 1) && in_last && (w_bytes == 4'd8)) begin
                w_fill[k] = MARK_WORD;
            end
        end
    end

    always_comb begin
        w_pad_blk                  = r_buf;
        w_pad_blk[FIN_BIT_WORD][0] = 1'b1;
        w_pad_blk[LEN_HI_IDX]      = r_len[127:64];
        w_pad_blk[LEN_LO_IDX]      = r_len[63:0];

        w_xpad_blk                  = '0;
        w_xpad_blk[0]               = r_p128 ? MARK_WORD : '0;
        w_xpad_blk[FIN_BIT_WORD][0] = 1'b1;
        w_xpad_blk[LEN_HI_IDX]      = r_len[127:64];
        w_xpad_blk[LEN_LO_IDX]      = r_len[63:0];
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_state        <= ST_FILL;
            r_wi           <= '0;
            r_len          <= '0;
            r_xpad_pending <= 1'b0;
            r_p128         <= 1'b0;
            // NOTE: the block buffer is explicitly cleared so no stale message data survives reset.
            r_buf          <= '0;
            r_blk_data     <= '0;
            r_blk_start    <= 1'b0;
            r_blk_final    <= 1'b0;
            r_blk_t        <= '0;
        end else begin
            r_blk_start <= 1'b0;
            case (r_state)
                ST_FILL: begin
                    if (w_accept) begin
                        r_buf <= w_fill;
                        r_len <= w_len_next;
                        if (!in_last) begin
                            r_wi <= r_wi + 4'd1;
                            if (r_wi == 4'(BLK_WORDS - 1)) begin
                                r_blk_data  <= w_fill;
                                r_blk_t     <= w_len_next;
                                r_blk_final <= 1'b0;
                                r_blk_start <= 1'b1;
                                r_state     <= ST_RUN;
                            end
                        end else if (w_p <= 8'd111) begin
                            r_state <= ST_PAD;
                        end else begin
                            // Length does not fit: issue data (plus marker if p<128) now, length block later.
                            r_blk_data     <= w_fill;
                            r_blk_t        <= w_len_next;
                            r_blk_final    <= 1'b0;
                            r_blk_start    <= 1'b1;
                            r_xpad_pending <= 1'b1;
                            r_p128         <= (w_p == 8'd128);
                            r_state        <= ST_RUN;
                        end
                    end
                end
                ST_PAD: begin
                    r_blk_data  <= w_pad_blk;
                    r_blk_t     <= r_len;
                    r_blk_final <= 1'b1;
                    r_blk_start <= 1'b1;
                    r_state     <= ST_RUN;
                end
                ST_RUN: begin
                    if (core_done) begin
                        if (r_xpad_pending) begin
                            r_state <= ST_XPAD;
                        end else begin
                            r_wi <= '0;
                            if (r_blk_final) begin
                                r_len <= '0;
                            end
                            r_state <= ST_FILL;
                        end
                    end
                end
                ST_XPAD: begin
                    r_blk_data     <= w_xpad_blk;
                    r_blk_t        <= '0;
                    r_blk_final    <= 1'b1;
                    r_blk_start    <= 1'b1;
                    r_xpad_pending <= 1'b0;
                    r_state        <= ST_RUN;
                end
                default: r_state <= ST_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_blake512_msg_loader.sv
// Scoreboard bench for blake512_msg_loader: directed messages push expected
// blocks; a monitor pops and compares on every blk_start.
module tb_blake512_msg_loader;

    typedef logic [0:15][63:0] words_t;
    typedef struct {
        words_t       w;
        logic [127:0] t;
        logic         fin;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstb;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic          in_last;
    logic [3:0]    in_bytes;
    logic          blk_start;
    logic [1023:0] blk_data;
    logic [127:0]  blk_t;
    logic          blk_final;
    logic          core_done;
    logic          done_auto;
    logic          done_man;
    logic          auto_done;

    exp_t   sb_q[$];
    exp_t   mon_e;
    words_t mon_a;
    words_t eb;
    int     checks = 0;
    int     errors = 0;
    int     blk_no = 0;

    always #5 clk = ~clk;

    assign core_done = done_auto | done_man;

    blake512_msg_loader dut (
        .clk       (clk),
        .rstb      (rstb),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .blk_start (blk_start),
        .blk_data  (blk_data),
        .blk_t     (blk_t),
        .blk_final (blk_final),
        .core_done (core_done)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] dw(input int k);
        logic [7:0] b;
        b = 8'(k + 1);
        return {8{b}};
    endfunction

    task automatic expect_blk(input words_t w, input logic [127:0] t, input logic fin);
        exp_t e;
        e.w   = w;
        e.t   = t;
        e.fin = fin;
        sb_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
        int budget;
        budget   = 300;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_bytes = nb;
        while (!in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_word_timeout act=in_ready_low exp=in_ready_high");
        end
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int budget;
        budget = 1000;
        while (!(sb_q.size() == 0 && in_ready) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!(sb_q.size() == 0 && in_ready)) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout act=pending%0d exp=pending0", sb_q.size());
        end
    endtask

    // Round-engine stand-in: acknowledges each block a few cycles after blk_start.
    initial begin
        done_auto = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (blk_start && auto_done) begin
                repeat (3) @(negedge clk);
                done_auto = 1'b1;
                @(negedge clk);
                done_auto = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (blk_start === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_blk_start act=1 exp=0");
                end else begin
                    mon_e = sb_q.pop_front();
                    mon_a = blk_data;
                    for (int k = 0; k < 16; k++) begin
                        check($sformatf("blk%0d_w%0d", blk_no, k), 128'(mon_a[k]), 128'(mon_e.w[k]));
                    end
                    check($sformatf("blk%0d_t", blk_no), blk_t, mon_e.t);
                    check($sformatf("blk%0d_final", blk_no), 128'(blk_final), 128'(mon_e.fin));
                    blk_no++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstb      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        in_bytes  = '0;
        done_man  = 1'b0;
        auto_done = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_blk_start", 128'(blk_start), 128'(0));
        check("rst_blk_final", 128'(blk_final), 128'(0));
        check("rst_blk_t", blk_t, 128'(0));
        check("rst_blk_data_zero", 128'(|blk_data), 128'(0));
        rstb = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 128'(in_ready), 128'(1));

        // Empty message
        eb = '0;
        eb[0]  = 64'h8000000000000000;
        eb[13] = 64'd1;
        expect_blk(eb, 128'd0, 1'b1);
        send_word(64'h0, 1'b1, 4'd0);
        in_valid = 1'b0;
        wait_idle();

        // "abc" with junk in the masked bytes
        eb = '0;
        eb[0]  = 64'h6162638000000000;
        eb[13] = 64'd1;
        eb[15] = 64'h18;
        expect_blk(eb, 128'd24, 1'b1);
        send_word(64'h616263FFFFFFFFFF, 1'b1, 4'd3);
        in_valid = 1'b0;
        wait_idle();

        // 111 bytes: marker lands on the final-bit byte (0x81)
        eb = '0;
        for (int k = 0; k < 13; k++) eb[k] = dw(k);
        eb[13] = 64'h0E0E0E0E0E0E0E81;
        eb[15] = 64'h378;
        expect_blk(eb, 128'd888, 1'b1);
        for (int k = 0; k < 13; k++) send_word(dw(k), 1'b0, 4'd0);
        send_word(64'h0E0E0E0E0E0E0EFF, 1'b1, 4'd7);
        in_valid = 1'b0;
        wait_idle();

        // 112 bytes: marker in word 14, length spills to an extra block
        eb = '0;
        for (int k = 0; k < 14; k++) eb[k] = dw(k);
        eb[14] = 64'h8000000000000000;
        expect_blk(eb, 128'd896, 1'b0);
        eb = '0;
        eb[13] = 64'd1;
        eb[15] = 64'h380;
        expect_blk(eb, 128'd0, 1'b1);
        for (int k = 0; k < 13; k++) send_word(dw(k), 1'b0, 4'd0);
        send_word(dw(13), 1'b1, 4'd8);
        in_valid = 1'b0;
        wait_idle();

        // 128 bytes: full data block, marker moves to the extra block
        eb = '0;
        for (int k = 0; k < 16; k++) eb[k] = dw(k);
        expect_blk(eb, 128'd1024, 1'b0);
        eb = '0;
        eb[0]  = 64'h8000000000000000;
        eb[13] = 64'd1;
        eb[15] = 64'h400;
        expect_blk(eb, 128'd0, 1'b1);
        for (int k = 0; k < 15; k++) send_word(dw(k), 1'b0, 4'd0);
        send_word(dw(15), 1'b1, 4'd8);
        check("t5_start_after_w15", 128'(blk_start), 128'(1));
        in_valid = 1'b0;
        wait_idle();

        // 17 words with in_valid held through ST_RUN; in_bytes=12 saturates to 8
        auto_done = 1'b0;
        eb = '0;
        for (int k = 0; k < 16; k++) eb[k] = dw(k);
        expect_blk(eb, 128'd1024, 1'b0);
        eb = '0;
        eb[0]  = dw(16);
        eb[1]  = 64'h8000000000000000;
        eb[13] = 64'd1;
        eb[15] = 64'h440;
        expect_blk(eb, 128'd1088, 1'b1);
        for (int k = 0; k < 16; k++) send_word(dw(k), 1'b0, 4'd0);
        in_data  = dw(16);
        in_last  = 1'b1;
        in_bytes = 4'd12;
        for (int i = 0; i < 3; i++) begin
            check("t6_ready_low_run", 128'(in_ready), 128'(0));
            @(negedge clk);
        end
        done_man = 1'b1;
        check("t6_ready_low_done_cycle", 128'(in_ready), 128'(0));
        @(negedge clk);
        done_man  = 1'b0;
        auto_done = 1'b1;
        check("t6_ready_after_done", 128'(in_ready), 128'(1));
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle();

        // Reset after 5 words discards them; "abc" then starts from a clean count
        for (int k = 0; k < 5; k++) send_word(dw(k), 1'b0, 4'd0);
        in_valid = 1'b0;
        rstb     = 1'b0;
        @(negedge clk);
        check("t6_rst_in_ready", 128'(in_ready), 128'(0));
        check("t6_rst_blk_data_zero", 128'(|blk_data), 128'(0));
        check("t6_rst_blk_t", blk_t, 128'(0));
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        eb = '0;
        eb[0]  = 64'h6162638000000000;
        eb[13] = 64'd1;
        eb[15] = 64'h18;
        expect_blk(eb, 128'd24, 1'b1);
        send_word(64'h6162630000000000, 1'b1, 4'd3);
        in_valid = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);

        check("queue_drained", 128'(sb_q.size()), 128'(0));
        check("block_count", 128'(blk_no), 128'(10));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
